apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Single-outstanding APB initiator: converts a simple valid/ready request port into
//  APB SETUP/ACCESS transfers toward the APB_sys_0 peripheral slaves (timers, GPIO, etc.).
//  Returns read data, slave error or timeout through a one-cycle response pulse.
//  Sits between the system-side command source (CPU bridge/DMA) and the APB fabric.
// PARAMETERS
//  ADDR_W          20   APB byte-address width; PADDR[ADDR_W-1:0]. Slaves decode PADDR[19:2].
//  TIMEOUT_CYCLES  256  Max ACCESS cycles with PREADY low before abort (APB_MASTER_TIMEOUT_EN only).
// PORTS
//  PCLK        in   1       APB clock; all logic rising-edge.
//  PRESETn     in   1       Asynchronous, active-low reset.
//  req_valid   in   1       Request present.
//  req_ready   out  1       Request accepted when req_valid & req_ready at PCLK edge.
//  req_addr    in   ADDR_W  Byte address; bits [1:0] ignored.
//  req_write   in   1       1 = write, 0 = read.
//  req_wdata   in   32      Write data.
//  rsp_valid   out  1       One-cycle completion pulse.
//  rsp_rdata   out  32      Read data (0 for writes and timeouts).
//  rsp_err     out  1       PSLVERR sampled at completion, or timeout.
//  PSEL        out  1       APB select.
//  PADDR       out  ADDR_W  APB address, [1:0] forced 0.
//  PENABLE     out  1       APB access phase.
//  PWRITE      out  1       APB direction.
//  PWDATA      out  32      APB write data.
//  PRDATA      in   32      APB read data.
//  PREADY      in   1       Slave ready / wait-state extension.
//  PSLVERR     in   1       Slave error; only sampled when PENABLE & PREADY.
// BEHAVIOUR
//  - Reset (async): state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata,
//    rsp_err all 0. Reset mid-transfer aborts instantly; no response pulse is issued.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE. All APB outputs are registered.
//  - IDLE: req_ready=1. On req_valid: latch addr/write/wdata into PADDR/PWRITE/PWDATA,
//    PSEL<=1, PENABLE<=0, go SETUP.
//  - SETUP: exactly one cycle; PENABLE<=1, go ACCESS. req_ready=0.
//  - ACCESS: req_ready=0. If PREADY=1: PSEL<=0, PENABLE<=0, rsp_valid<=1 for one cycle,
//    rsp_err<=PSLVERR, rsp_rdata<=PWRITE ? 0 : PRDATA, go IDLE. Else remain (wait state).
//  - PADDR/PWRITE/PWDATA stable from SETUP through end of ACCESS; hold last value in IDLE.
//  - Zero-wait transfer: accept at edge N, SETUP cycle N+1, ACCESS N+2, rsp_valid in
//    cycle N+3 (same cycle IDLE re-accepts). Max throughput 1 transfer / 3 cycles.
//  - rsp_valid coincident with a new accept is legal; the two are independent.
//  - Unaligned req_addr (e.g. 0x00007) -> PADDR 0x00004; no error raised.
//  - rsp_rdata/rsp_err hold their value until the next completion.
// CONFIGURATION
//  APB_MASTER_TIMEOUT_EN defined: counter cleared on SETUP entry, increments each ACCESS
//    cycle with PREADY=0; when count reaches TIMEOUT_CYCLES the transfer aborts:
//    PSEL/PENABLE<=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, go IDLE.
//    PREADY=1 in the same cycle as the limit wins (normal completion).
//  Not defined: no counter; ACCESS waits indefinitely for PREADY.
// TESTING
//  1. Write 0x000FF to 0x00004, PREADY=1 -> PSEL 2 cycles, PENABLE 2nd only,
//     PADDR=0x00004, PWDATA=0xFF, PWRITE=1; rsp_valid 1 cycle at N+3, err=0, rdata=0.
//  2. Read 0x0000C, PREADY low 3 ACCESS cycles, PRDATA=0xDEADBEEF -> ACCESS 4 cycles,
//     address/control stable, rsp_rdata=0xDEADBEEF, rsp_err=0.
//  3. Write with PSLVERR=1 at completion -> rsp_err=1; PSLVERR=1 during wait states ignored.
//  4. req_valid held high for 4 reads -> accepted every 3 cycles, req_ready low in
//     SETUP/ACCESS, 4 rsp_valid pulses in order with matching data.
//  5. APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY stuck 0 -> abort after 16 ACCESS
//     cycles, rsp_err=1, rdata=0; without macro still in ACCESS after 1000 cycles.
//  6. PRESETn low during ACCESS -> PSEL/PENABLE 0 immediately, no rsp_valid; after
//     release a read of 0x00000 completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready request port to APB SETUP/ACCESS transfers.
// Optional ACCESS wait-state timeout is enabled with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int ADDR_W         = 20,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [31:0]       pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              timeout;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts stalled ACCESS cycles; the abort fires on the last allowed stalled cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE && req_valid) begin
         cnt_d = '0;
      end else if (state_q == ACCESS && !PREADY) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign timeout = (state_q == ACCESS) && !PREADY &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (PREADY || timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address/control hold their last value outside a transfer; only IDLE reloads them.
   always_comb begin
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               paddr_d   = req_addr & ~ADDR_W'(3);
               pwrite_d  = req_write;
               pwdata_d  = req_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (PREADY) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = PSLVERR;
               rsp_rdata_d = pwrite_q ? 32'd0 : PRDATA;
            end else if (timeout) begin
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 32'd0;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed plus randomized bench for apb_master_bridge; expected responses come from the
// transfer parameters chosen here (aligned address, read data or zero, completion error).
module tb_apb_master_bridge;

   localparam int ADDR_W = 20;
   localparam int TO     = 256;

   logic              PCLK = 1'b0;
   logic              PRESETn = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr = '0;
   logic              req_write = 1'b0;
   logic [31:0]       req_wdata = '0;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              PSEL;
   logic [ADDR_W-1:0] PADDR;
   logic              PENABLE;
   logic              PWRITE;
   logic [31:0]       PWDATA;
   logic [31:0]       PRDATA = '0;
   logic              PREADY = 1'b0;
   logic              PSLVERR = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   apb_master_bridge #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed no finish, required finish before 5ms");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // One complete transfer with `waits` stalled ACCESS cycles. Entered and left 1 time unit
   // after a rising edge with the bridge idle.
   task automatic xfer(input logic [ADDR_W-1:0] a, input logic w, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input logic err,
                       input logic err_in_wait);
      logic [ADDR_W-1:0] exp_addr;
      logic [31:0]       exp_rdata;
      logic              hold_ok;
      exp_addr  = {a[ADDR_W-1:2], 2'b00};
      exp_rdata = w ? 32'd0 : rd;
      hold_ok   = 1'b1;
      chk("idle_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd;
      step();
      req_valid = 1'b0; req_addr = ~a; req_write = ~w; req_wdata = ~wd;
      chk("setup_psel",    {31'd0, PSEL},      32'd1);
      chk("setup_penable", {31'd0, PENABLE},   32'd0);
      chk("setup_ready",   {31'd0, req_ready}, 32'd0);
      chk("setup_paddr",   {12'd0, PADDR},     {12'd0, exp_addr});
      chk("setup_pwrite",  {31'd0, PWRITE},    {31'd0, w});
      chk("setup_pwdata",  PWDATA,             wd);
      step();
      for (int i = 0; i < waits; i++) begin
         PREADY = 1'b0; PSLVERR = err_in_wait; PRDATA = $urandom;
         if (!(PSEL && PENABLE && !req_ready && !rsp_valid && PADDR == exp_addr &&
               PWRITE == w && PWDATA == wd)) hold_ok = 1'b0;
         step();
      end
      PREADY = 1'b1; PSLVERR = err; PRDATA = rd;
      chk("access_hold",    {31'd0, hold_ok}, 32'd1);
      chk("access_penable", {31'd0, PENABLE}, 32'd1);
      chk("access_paddr",   {12'd0, PADDR},   {12'd0, exp_addr});
      step();
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
      chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_rdata", rsp_rdata,          exp_rdata);
      chk("rsp_err",   {31'd0, rsp_err},   {31'd0, err});
      chk("done_psel", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("done_ready", {31'd0, req_ready}, 32'd1);
      step();
      chk("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
      chk("rsp_hold",      {rsp_rdata[30:0], rsp_err}, {exp_rdata[30:0], err});
      chk("idle_paddr_hold", {12'd0, PADDR}, {12'd0, exp_addr});
   endtask

   initial begin
      logic [ADDR_W-1:0] addrs [4];
      logic [31:0]       datas [4];
      logic              ok;
      int                c;

      // Reset state
      #2;
      chk("rst_psel",    {30'd0, PSEL, PENABLE}, 32'd0);
      chk("rst_paddr",   {12'd0, PADDR},  32'd0);
      chk("rst_pwdata",  PWDATA,          32'd0);
      chk("rst_pwrite",  {31'd0, PWRITE}, 32'd0);
      chk("rst_rsp",     {30'd0, rsp_valid, rsp_err}, 32'd0);
      chk("rst_rdata",   rsp_rdata,       32'd0);
      chk("rst_ready",   {31'd0, req_ready}, 32'd1);
      step();
      PRESETn = 1'b1;
      step();

      // Directed transfers
      xfer(20'h00004, 1'b1, 32'h0000_00FF, 0, 32'h1234_5678, 1'b0, 1'b0);
      xfer(20'h0000C, 1'b0, 32'h0,         3, 32'hDEAD_BEEF, 1'b0, 1'b0);
      xfer(20'h00020, 1'b1, 32'hA5A5_0001, 2, 32'h0,         1'b1, 1'b1);
      xfer(20'h00030, 1'b0, 32'h0,         2, 32'h0BAD_F00D, 1'b0, 1'b1);
      xfer(20'h00007, 1'b0, 32'h0,         0, 32'h7777_0007, 1'b0, 1'b0);

      // Randomized transfers
      for (int n = 0; n < 24; n++) begin
         xfer(ADDR_W'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 4)),
              $urandom, 1'($urandom), 1'($urandom));
      end

      // Back-to-back reads with req_valid held high: one transfer every 3 cycles
      for (int k = 0; k < 4; k++) begin
         addrs[k] = ADDR_W'($urandom);
         datas[k] = $urandom;
      end
      PREADY = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = addrs[0];
      for (c = 0; c < 12; c++) begin
         PRDATA = datas[c / 3];
         step();
         case (c % 3)
            0: begin
               chk("b2b_setup", {29'd0, PSEL, PENABLE, req_ready}, 32'b100);
               chk("b2b_paddr", {12'd0, PADDR}, {12'd0, addrs[c / 3][ADDR_W-1:2], 2'b00});
               chk("b2b_norsp", {31'd0, rsp_valid}, 32'd0);
            end
            1: begin
               chk("b2b_access", {29'd0, PSEL, PENABLE, req_ready}, 32'b110);
               chk("b2b_norsp", {31'd0, rsp_valid}, 32'd0);
               if (c / 3 < 3) req_addr = addrs[c / 3 + 1];
               else req_valid = 1'b0;
            end
            default: begin
               chk("b2b_rsp",   {30'd0, rsp_valid, req_ready}, 32'b11);
               chk("b2b_rdata", rsp_rdata, datas[c / 3]);
            end
         endcase
      end
      PREADY = 1'b0;
      step();
      chk("b2b_drained", {30'd0, PSEL, rsp_valid}, 32'd0);
      step();

      // PREADY stuck low
      req_valid = 1'b1; req_write = 1'b0; req_addr = 20'h00040;
      step();
      req_valid = 1'b0;
      step();
      ok = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
      for (int i = 0; i < TO; i++) begin
         if (!(PSEL && PENABLE && !rsp_valid)) ok = 1'b0;
         step();
      end
      chk("to_wait_hold", {31'd0, ok}, 32'd1);
      chk("to_rsp",       {29'd0, rsp_valid, rsp_err, PSEL}, 32'b110);
      chk("to_rdata",     rsp_rdata, 32'd0);
      step();
`else
      for (int i = 0; i < 1000; i++) begin
         if (!(PSEL && PENABLE && !rsp_valid && !req_ready)) ok = 1'b0;
         step();
      end
      chk("stall_hold", {31'd0, ok}, 32'd1);
      PREADY = 1'b1; PRDATA = 32'hC0FF_EE00;
      step();
      PREADY = 1'b0;
      chk("stall_rsp",   {30'd0, rsp_valid, rsp_err}, 32'b10);
      chk("stall_rdata", rsp_rdata, 32'hC0FF_EE00);
      step();
`endif

      // Reset during ACCESS
      req_valid = 1'b1; req_write = 1'b1; req_addr = 20'h00100; req_wdata = 32'h5555_AAAA;
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("pre_rst_access", {30'd0, PSEL, PENABLE}, 32'b11);
      PRESETn = 1'b0;
      #1;
      chk("arst_psel",  {30'd0, PSEL, PENABLE}, 32'd0);
      chk("arst_rsp",   {31'd0, rsp_valid},     32'd0);
      chk("arst_paddr", {12'd0, PADDR},         32'd0);
      PREADY = 1'b1;
      step();
      PRESETn = 1'b1;
      PREADY = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (rsp_valid || PSEL || !req_ready) ok = 1'b0;
      end
      chk("post_rst_quiet", {31'd0, ok}, 32'd1);
      xfer(20'h00000, 1'b0, 32'h0, 1, 32'h1357_9BDF, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
